ring_rr_arbiter: RTL and testbench
==================================

Name: ring_rr_arbiter

Overview:
- Round-robin arbiter sharing one resource among N requesters.
- Priority is held in a one-hot rotating ring token with the same shift order as the team's 4-bit ring counter (bit3 -> bit2 -> bit1 -> bit0 -> bit3).
- Grants are registered and held until the owner releases or a hold limit expires, then the token advances past the owner.
- Sits between requesting blocks and a shared datapath or resource.

Parameters:
- N, 4, number of requesters; must be >= 2.
- MAX_HOLD, 8, maximum consecutive cycles one grant may be held; must be >= 1.
- HW, $clog2(MAX_HOLD+1), hold-counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- clr_n  input  1  asynchronous active-low reset.
- req  input  N  request vector; bit i high = requester i wants the resource.
- grant  output  N  registered one-hot grant, or all-zero.
- grant_id  output  $clog2(N)  binary index of the asserted grant bit; 0 when grant == 0.
- busy  output  1  high while in GRANT state.
- preempt  output  1  one-cycle pulse when a grant is revoked by hold-limit expiry.

Behaviour:
- Reset: clr_n low asynchronously forces the following values.
  - state = IDLE
  - token = one-hot bit N-1 (4'b1000 for N=4)
  - grant = 0, grant_id = 0, busy = 0, preempt = 0
  - hold counter = 0
- Reset release: synchronous to clk. The first active edge is the first edge with clr_n high.
- Search order: start at the token bit, then token-1, ..., bit 0, wrap to bit N-1, stop before the token. The first asserted req bit wins.
- States:
  - IDLE
    - req == 0: stay in IDLE.
    - Otherwise: at the next edge, grant = winner, grant_id = winner index, busy = 1, hold = 1, go to GRANT.
    - Latency: req sampled high at edge t gives grant visible after edge t (one cycle).
  - GRANT
    - Owner's req bit still high and hold < MAX_HOLD: hold the grant and increment hold.
    - Owner's req bit low: release. grant = 0, busy = 0, go to GAP.
    - Owner's req still high and hold == MAX_HOLD: release as above, and preempt = 1 for exactly that cycle.
    - Either release: token advances to the position one step after the owner in shift order (owner bit i -> token bit i-1, bit 0 -> bit N-1).
    - Requests from other requesters are ignored while in GRANT. No mid-grant switching.
  - GAP
    - One mandatory idle cycle: grant = 0, preempt returns to 0.
    - Next edge goes to IDLE behaviour, i.e. arbitration happens on the edge leaving GAP.
    - Minimum grant-to-grant turnaround: one empty cycle.
- Invariants:
  - grant is one-hot or zero at all times.
  - token is always exactly one-hot. Any illegal token value recovers to bit N-1 on the next edge.
  - hold never exceeds MAX_HOLD. Hold wraps to 0 on every release.
- Simultaneous events:
  - Owner drops req on the same edge the hold limit is reached: treat as a normal release, preempt = 0.
  - Preempted requester keeps req high: it competes again after GAP, now with the lowest priority.
- Reset mid-grant: grant drops immediately (asynchronous). The token returns to bit N-1. No preempt pulse.
- MAX_HOLD = 1: every grant lasts exactly one cycle. Preempt pulses whenever the owner is still requesting.

Test Plan:
- Reset, then req=4'b1111 held: grants cycle 1000, 0100, 0010, 0001, 1000, each lasting 8 cycles with a preempt pulse and one zero-grant gap between them.
- After reset, req=4'b0001 pulsed for 3 cycles: grant=0001 one cycle after req rises, held 3 cycles, grant_id=0, preempt never asserts, token becomes 1000.
- Owner 0100 drops req while req=4'b1011: gap cycle, then grant=0010 (not 1000); confirms rotation past the owner.
- During GRANT to 1000, raise req[0]: grant stays 1000 until release, no glitch on other grant bits, then 0001 granted after the gap.
- Assert clr_n low mid-grant (hold=5): grant, busy and preempt go 0 before the next edge; after release with req=4'b0011, the first grant is 0010.
- MAX_HOLD=1 build, req=4'b1001 constant: grant alternates 1000, gap, 0001, gap, with preempt on every release.

Source files
------------

// File: rtl/ring_rr_arbiter_if.sv
// ring_rr_arbiter_if: request/grant bundle between requesters and the ring arbiter
interface ring_rr_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]         req;
  logic [N-1:0]         grant;
  logic [$clog2(N)-1:0] grant_id;
  logic                 busy;
  logic                 preempt;
  modport master(output req, input grant, grant_id, busy, preempt);
  modport slave(input req, output grant, grant_id, busy, preempt);
endinterface

// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter: round-robin arbiter with a one-hot rotating token and a hold limit
module ring_rr_arbiter #(
  parameter int N = 4,
  parameter int MAX_HOLD = 8,
  localparam int HW = $clog2(MAX_HOLD + 1),
  localparam int IW = $clog2(N)
) (
  input logic clk,
  input logic clr_n,
  ring_rr_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] GRANT = 2'b01;
  localparam logic [1:0] GAP   = 2'b10;
  localparam logic [N-1:0] TOK_RST = {1'b1, {(N-1){1'b0}}};
  logic [1:0]    state_q, state_d;
  logic [N-1:0]  token_q, token_d, grant_q, grant_d, tok;
  logic [IW-1:0] gid_q, gid_d, start, win_idx;
  logic [HW-1:0] hold_q, hold_d;
  logic          preempt_q, preempt_d, win_ok, own_req;
  assign tok     = $onehot(token_q) ? token_q : TOK_RST;
  assign own_req = |(bus.req & grant_q);
  // find the first requester at or below the token, wrapping from bit 0 to bit N-1
  always_comb begin
    start = '0;
    for (int i = 0; i < N; i++) if (tok[i]) start = IW'(i);
    win_ok  = 1'b0;
    win_idx = '0;
    for (int k = 0; k < N; k++)
      if (!win_ok && bus.req[(int'(start) + N - k) % N]) begin
        win_ok  = 1'b1;
        win_idx = IW'((int'(start) + N - k) % N);
      end
  end
  // GRANT holds or releases; IDLE and GAP both arbitrate on their leaving edge
  always_comb begin
    state_d   = state_q;
    token_d   = tok;
    grant_d   = grant_q;
    gid_d     = gid_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    if (state_q == GRANT) begin
      if (own_req && hold_q < HW'(MAX_HOLD)) hold_d = hold_q + HW'(1);
      else begin
        state_d   = GAP;
        grant_d   = '0;
        gid_d     = '0;
        hold_d    = '0;
        preempt_d = own_req;
        token_d   = {grant_q[0], grant_q[N-1:1]};
      end
    end else if (win_ok) begin
      state_d = GRANT;
      grant_d = N'(1) << win_idx;
      gid_d   = win_idx;
      hold_d  = HW'(1);
    end else state_d = IDLE;
  end
  // state registers with asynchronous clear
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      token_q   <= TOK_RST;
      grant_q   <= '0;
      gid_q     <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      token_q   <= token_d;
      grant_q   <= grant_d;
      gid_q     <= gid_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end
  assign bus.grant    = grant_q;
  assign bus.grant_id = gid_q;
  assign bus.busy     = state_q == GRANT;
  assign bus.preempt  = preempt_q;
endmodule

// File: tb/tb_ring_rr_arbiter.sv
// tb_ring_rr_arbiter: scoreboard bench running MAX_HOLD=8 and MAX_HOLD=1 arbiters side by side
module tb_ring_rr_arbiter;
  localparam int N = 4;
  typedef struct {int owner; int prio; int hold; logic pre;} ms_t;
  typedef struct {
    logic [3:0] g8, g1;
    logic [1:0] id8, id1;
    logic b8, b1, p8, p1;
  } exp_t;
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic [3:0] req = '0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  ms_t m8, m1;
  ring_rr_arbiter_if #(.N(N)) b8();
  ring_rr_arbiter_if #(.N(N)) b1();
  assign b8.req = req;
  assign b1.req = req;
  ring_rr_arbiter #(.N(N), .MAX_HOLD(8)) dut8(.clk(clk), .clr_n(clr_n), .bus(b8));
  ring_rr_arbiter #(.N(N), .MAX_HOLD(1)) dut1(.clk(clk), .clr_n(clr_n), .bus(b1));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  function automatic ms_t mreset();
    ms_t s;
    s.owner = -1;
    s.prio  = N - 1;
    s.hold  = 0;
    s.pre   = 1'b0;
    return s;
  endfunction
  // priority pointer walks downward from prio; a release moves prio one below the owner
  function automatic ms_t mstep(input ms_t s0, input logic [3:0] r, input int mh);
    ms_t s = s0;
    s.pre = 1'b0;
    if (s.owner >= 0) begin
      if (r[s.owner] && s.hold < mh) s.hold++;
      else begin
        s.pre   = r[s.owner];
        s.prio  = (s.owner + N - 1) % N;
        s.owner = -1;
        s.hold  = 0;
      end
    end else
      for (int k = 0; k < N; k++) begin
        int i = (s.prio - k + N) % N;
        if (s.owner < 0 && r[i]) begin
          s.owner = i;
          s.hold  = 1;
        end
      end
    return s;
  endfunction
  function automatic exp_t mexp();
    exp_t e;
    e.g8  = m8.owner >= 0 ? 4'(1 << m8.owner) : 4'b0;
    e.id8 = m8.owner >= 0 ? 2'(m8.owner) : 2'd0;
    e.b8  = m8.owner >= 0;
    e.p8  = m8.pre;
    e.g1  = m1.owner >= 0 ? 4'(1 << m1.owner) : 4'b0;
    e.id1 = m1.owner >= 0 ? 2'(m1.owner) : 2'd0;
    e.b1  = m1.owner >= 0;
    e.p1  = m1.pre;
    return e;
  endfunction
  task automatic cyc(input logic [3:0] r);
    @(negedge clk);
    clr_n = 1'b1;
    req = r;
    m8 = mstep(m8, r, 8);
    m1 = mstep(m1, r, 1);
    sb.push_back(mexp());
  endtask
  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    #1;
    chk("rst_grant8", b8.grant, 0);
    chk("rst_busy8", b8.busy, 0);
    chk("rst_pre8", b8.preempt, 0);
    chk("rst_grant1", b1.grant, 0);
    chk("rst_pre1", b1.preempt, 0);
    m8 = mreset();
    m1 = mreset();
    sb.push_back(mexp());
  endtask
  task automatic hold_req(input logic [3:0] r, input int n);
    for (int i = 0; i < n; i++) cyc(r);
  endtask
  // monitor: compare every registered output one step after each active edge
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("grant8", b8.grant, e.g8);
      chk("gid8", b8.grant_id, e.id8);
      chk("busy8", b8.busy, e.b8);
      chk("pre8", b8.preempt, e.p8);
      chk("grant1", b1.grant, e.g1);
      chk("gid1", b1.grant_id, e.id1);
      chk("busy1", b1.busy, e.b1);
      chk("pre1", b1.preempt, e.p1);
      chk("onehot8", 32'($onehot0(b8.grant)), 1);
      chk("onehot1", 32'($onehot0(b1.grant)), 1);
    end
  end
  initial begin
    logic [3:0] r;
    m8 = mreset();
    m1 = mreset();
    do_reset();
    hold_req(4'b1111, 40);
    do_reset();
    hold_req(4'b0001, 3);
    hold_req(4'b0000, 3);
    do_reset();
    hold_req(4'b0100, 3);
    hold_req(4'b1011, 10);
    do_reset();
    hold_req(4'b1000, 3);
    hold_req(4'b1001, 3);
    hold_req(4'b0001, 6);
    do_reset();
    hold_req(4'b1111, 5);
    do_reset();
    hold_req(4'b0011, 6);
    hold_req(4'b1001, 12);
    r = 4'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else begin
        if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
        cyc(r);
      end
    end
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
